// File: rtl/booth_multiplier.sv
// Radix-2 Booth signed multiplier, one add/subtract-and-shift per clock.
// A WIDTH-bit operand pair produces a 2*WIDTH-bit registered product
// WIDTH cycles after the load edge. busy/done are Moore outputs of the FSM.
module booth_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // A carries one extra sign bit so that subtracting M = -2^(WIDTH-1)
    // cannot overflow the partial product.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_1_nxt;
    logic [CW-1:0]    count_nxt;
    logic             last_iter;
    logic             accept;

    // Operands are captured only outside RUN; ld during RUN is ignored.
    assign accept    = ld && (state_q != RUN);
    assign count_nxt = count + CW'(1);
    assign last_iter = (count_nxt == LAST);

    // Booth recode of {Q[0], Q_1}: 01 adds M, 10 subtracts M, else keep.
    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Arithmetic right shift of {A,Q,Q_1} by one with A's msb replicated.
    always_comb begin
        acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        q_1_nxt = q[0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (ld) state_d = RUN;
                else    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one Booth iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= '0;
            q     <= a;
            q_1   <= 1'b0;
            m     <= {b[WIDTH-1], b};
            count <= '0;
        end else if (state_q == RUN) begin
            acc   <= acc_nxt;
            q     <= q_nxt;
            q_1   <= q_1_nxt;
            count <= count_nxt;
        end
    end

    // Product register: written only on the final iteration, so it holds the
    // previous result through IDLE and any later RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (state_q == RUN && last_iter) begin
            p <= {acc_nxt[WIDTH-1:0], q_nxt};
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corners plus random
// operand pairs checked against a plain signed-multiply reference.
module tb_booth_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ld  = 1'b0;
    logic [W-1:0]   a   = '0;
    logic [W-1:0]   b   = '0;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .p    (p),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // Reference: exact signed product, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint r;
        r = longint'($signed(x)) * longint'($signed(y));
        return r[2*W-1:0];
    endfunction

    // Present operands with a one-cycle ld pulse; returns at the sample point
    // of the first cycle after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a  = x;
        b  = y;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Bounded wait for done; n = edges after the accepting edge, nb = cycles
    // seen with busy high before done, to = bound expired.
    task automatic wait_done(output int n, output int nb, output bit to);
        n  = 0;
        nb = 0;
        to = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!done) to = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ld  = 1'b1;
        a   = 16'h1111;
        b   = 16'h2222;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ld  = 1'b0;
        checks++;
        if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: p=%h busy=%b done=%b, want 0/0/0", p, busy, done);
        end
    endtask

    task automatic test_basic();
        int n, nb;
        bit to;
        start_op(16'd3, 16'd5);
        wait_done(n, nb, to);
        checks++;
        if (to || n != W || nb != W) begin
            errors++;
            $display("FAIL basic_latency: n=%0d busy_cycles=%0d timeout=%0b, want %0d/%0d/0", n, nb, to, W, W);
        end
        checks++;
        if (p !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_p: got %h want 0000000f", p);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || p !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_after: done=%b busy=%b p=%h, want 0/0/0000000f", done, busy, p);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{16'hFFF9, 16'h0006, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
        logic [W-1:0] tb [7] = '{16'h0006, 16'hFFF9, 16'h8000, 16'h8000, 16'h1234, 16'h7FFF, 16'h0001};
        int n, nb;
        bit to;
        for (int i = 0; i < 7; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(n, nb, to);
            checks++;
            if (to || p !== ref_mul(ta[i], tb[i])) begin
                errors++;
                $display("FAIL directed[%0d]: a=%h b=%h got %h want %h timeout=%0b",
                         i, ta[i], tb[i], p, ref_mul(ta[i], tb[i]), to);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic [2*W-1:0] prev;
        int n, nb;
        bit to;
        for (int i = 0; i < 24; i++) begin
            prev = p;
            x = W'($urandom);
            y = W'($urandom);
            start_op(x, y);
            // Scramble inputs during RUN; they must not be resampled.
            a = W'($urandom);
            b = W'($urandom);
            checks++;
            if (p !== prev || busy !== 1'b1) begin
                errors++;
                $display("FAIL random_hold[%0d]: p=%h busy=%b, want %h/1", i, p, busy, prev);
            end
            wait_done(n, nb, to);
            checks++;
            if (to || n != W || p !== ref_mul(x, y)) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h got %h want %h n=%0d", i, x, y, p, ref_mul(x, y), n);
            end
        end
    endtask

    task automatic test_ignored_ld();
        int n, nb, extra;
        bit to;
        start_op(16'd2, 16'd2);
        repeat (4) @(negedge clk);
        a  = 16'd9;
        b  = 16'd9;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_done(n, nb, to);
        checks++;
        if (to || n + 5 != W || p !== 32'h00000004) begin
            errors++;
            $display("FAIL ignored_ld: total=%0d p=%h, want %0d/00000004", n + 5, p, W);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra != 0 || p !== 32'h00000004) begin
            errors++;
            $display("FAIL ignored_ld_second_done: extra_dones=%0d p=%h, want 0/00000004", extra, p);
        end
    endtask

    task automatic test_reset_mid();
        int n, nb, extra;
        bit to;
        start_op(16'd3, 16'd5);
        wait_done(n, nb, to);
        checks++;
        if (to || p !== 32'h0000000F) begin
            errors++;
            $display("FAIL rstmid_prior: got %h want 0000000f", p);
        end
        start_op(16'd100, 16'd100);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL rstmid_abort: busy=%b done=%b p=%h, want 0/0/0", busy, done, p);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: active_cycles=%0d want 0", extra);
        end
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(n, nb, to);
        checks++;
        if (to || p !== 32'h00000001) begin
            errors++;
            $display("FAIL rstmid_after: got %h want 00000001", p);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] first;
        int n, nb;
        bit to;
        start_op(16'h0123, 16'hFF00);
        wait_done(n, nb, to);
        first = ref_mul(16'h0123, 16'hFF00);
        checks++;
        if (to || p !== first) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", p, first);
        end
        // Sitting in DONE: raise ld and keep it high.
        a  = 16'hABCD;
        b  = 16'h0042;
        ld = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || p !== first) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b p=%h, want 1/0/%h", busy, done, p, first);
        end
        wait_done(n, nb, to);
        checks++;
        if (to || n != W || p !== ref_mul(16'hABCD, 16'h0042)) begin
            errors++;
            $display("FAIL b2b_second: n=%0d got %h want %0d/%h", n, p, W, ref_mul(16'hABCD, 16'h0042));
        end
        // ld still high in DONE: a third operation starts; p must hold.
        a = 16'h8000;
        b = 16'hFFFF;
        @(negedge clk);
        ld = 1'b0;
        checks++;
        if (busy !== 1'b1 || p !== ref_mul(16'hABCD, 16'h0042)) begin
            errors++;
            $display("FAIL b2b_third_start: busy=%b p=%h", busy, p);
        end
        wait_done(n, nb, to);
        checks++;
        if (to || n != W || p !== ref_mul(16'h8000, 16'hFFFF)) begin
            errors++;
            $display("FAIL b2b_third: n=%0d got %h want %h", n, p, ref_mul(16'h8000, 16'hFFFF));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_ignored_ld();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; the product is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port ld, input, 1 bit: start request, which captures the operands.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplier, two's complement.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplicand, two's complement.
REQ-007 The block SHALL have port p, output, 2*WIDTH bits: signed product, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-010 The block SHALL implement radix-2 Booth signed multiplication with three states: IDLE, RUN, DONE.
REQ-011 Internal registers SHALL be:
- accumulator A, WIDTH+1 bits, with the extra sign bit so that b = -2^(WIDTH-1) cannot overflow;
- Q, WIDTH bits;
- Q_1, 1 bit;
- M, WIDTH+1 bits (b sign-extended);
- count, clog2(WIDTH)+1 bits.
REQ-012 In IDLE or DONE, when ld=1 at an edge, the block SHALL load A=0, Q=a, Q_1=0, M=sext(b) and count=0, and SHALL move to RUN.
REQ-013 In each RUN edge, the block SHALL first update A according to {Q[0],Q_1}:
- 01: A=A+M;
- 10: A=A-M;
- 00 or 11: A unchanged.
REQ-014 In the same RUN edge, the block SHALL then arithmetic-shift-right {A,Q,Q_1} by one (A msb replicated) and increment count.
REQ-015 The RUN edge on which count reaches WIDTH SHALL write p={A[WIDTH-1:0],Q} using the post-shift values, and SHALL move to DONE.
REQ-016 Latency: with ld sampled at edge E0, iterations SHALL occur at E1..E_WIDTH, so done=1 and p is valid in the cycle after E_WIDTH (16 cycles after ld for WIDTH=16).
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE, unless ld=1 in DONE, which starts a new operation per REQ-012.
REQ-018 The outputs SHALL be Moore outputs of the state:
- busy=1 exactly in RUN;
- done=1 exactly in DONE.
REQ-019 ld SHALL be ignored while in RUN: no operand recapture and no latency change.
REQ-020 p SHALL change only at completion (REQ-015) or reset; it SHALL hold its last product through IDLE and through a subsequent RUN.
REQ-021 a and b SHALL be sampled only at the accepting ld edge; changes on a or b during RUN SHALL have no effect.
REQ-022 The result SHALL be the exact two's-complement product for all operand pairs, including -2^(WIDTH-1) x -2^(WIDTH-1).

Reset
REQ-023 When rst=1 at an edge, the block SHALL go to IDLE and clear p, A, Q, Q_1, M and count to 0, with busy=0 and done=0.
REQ-024 rst SHALL take priority over ld at the same edge.
REQ-025 rst asserted during RUN SHALL abort the operation with no done pulse; p SHALL read 0 afterwards.

Verification
REQ-026 Basic product: a=3, b=5, ld for one cycle -> busy high for 16 cycles, then done=1 for one cycle with p=0x0000000F.
REQ-027 Mixed signs: a=-7 (0xFFF9), b=6 -> p=0xFFFFFFD6 (-42); a=6, b=-7 -> same result.
REQ-028 Corner cases:
- a=b=0x8000 -> p=0x40000000;
- a=0x7FFF, b=0x8000 -> p=0xC0008000;
- a=0, b=0x1234 -> p=0.
REQ-029 Ignored ld: ld pulse with a=2, b=2; ld pulse with a=9, b=9 at cycle 5 of RUN -> single done at cycle 16 with p=0x00000004, no second done.
REQ-030 Reset mid-operation: rst at cycle 8 of RUN after a prior product 0x0F -> next cycle busy=0, done=0, p=0, no done pulse; a following ld with a=-1, b=-1 -> p=0x00000001.
REQ-031 Back-to-back: ld held high through DONE -> new operation starts from DONE, the next done follows 16 cycles later, and p holds the prior value until then.
